// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 8-bit, 4-instruction CPU
module imem_fetch_sequencer #(
    parameter logic [7:0] HALT_ADDR = 8'd255,
    parameter logic [7:0] RESET_PC  = 8'd0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Step,
    input  logic [7:0] Instruction,
    output logic [7:0] Read_Address,
    output logic [7:0] IR,
    output logic       ALUSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       Busy,
    output logic       Halted,
    output logic [7:0] Retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_n, end_state;
    logic [7:0] pc, pc_n, imm;
    logic [1:0] op;
    logic done;
    assign Read_Address = pc;
    always_comb begin
        op = IR[7:6];
        imm = {{6{IR[1]}}, IR[1:0]};
        pc_n = (state == FETCH) ? pc + 8'd1 : (state == EXEC && op == 2'b11) ? pc + imm : pc;
        done = (state == EXEC && op == 2'b11) || (state == MEM && op == 2'b10) || state == WB;
        end_state = (pc_n == HALT_ADDR) ? HALT : Run ? FETCH : IDLE;
        state_n = state;
        case (state)
            IDLE:    state_n = (pc == HALT_ADDR) ? HALT : (Run || Step) ? FETCH : IDLE;
            FETCH:   state_n = DECODE;
            DECODE:  state_n = EXEC;
            EXEC:    state_n = (op == 2'b11) ? end_state : (op == 2'b00) ? WB : MEM;
            MEM:     state_n = (op == 2'b01) ? WB : end_state;
            WB:      state_n = end_state;
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
    end
    // strobes are registered from the next state so they line up with the state they belong to
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            IR       <= '0;
            Retired  <= '0;
            ALUSrc   <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            MemToReg <= 1'b0;
            RegWrite <= 1'b0;
            Busy     <= 1'b0;
            Halted   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            IR       <= (state == FETCH) ? Instruction : IR;
            Retired  <= Retired + {7'd0, done};
            ALUSrc   <= (state_n == EXEC && (op == 2'b01 || op == 2'b10)) || (state_n == MEM && op == 2'b10);
            MemRead  <= state_n == MEM && op == 2'b01;
            MemWrite <= state_n == MEM && op == 2'b10;
            MemToReg <= state_n == WB && op == 2'b01;
            RegWrite <= state_n == WB;
            Busy     <= state_n != IDLE && state_n != HALT;
            Halted   <= state_n == HALT;
        end
    end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb_imem_fetch_sequencer: directed bench with a retirement scoreboard of expected post-instruction PCs
module tb_imem_fetch_sequencer;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_n, run, step, rst1_n, run1, step1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] instr0, pc0, ir0, ret0, instr1, pc1, ir1, ret1;
    logic as0, mr0, mw0, mtr0, rw0, busy0, halted0;
    logic as1, mr1, mw1, mtr1, rw1, busy1, halted1;

    assign instr0 = mem0[pc0];
    assign instr1 = mem1[pc1];

    imem_fetch_sequencer d0 (
        .Clk(Clk), .Reset_n(rst_n), .Run(run), .Step(step), .Instruction(instr0),
        .Read_Address(pc0), .IR(ir0), .ALUSrc(as0), .MemRead(mr0), .MemWrite(mw0),
        .MemToReg(mtr0), .RegWrite(rw0), .Busy(busy0), .Halted(halted0), .Retired(ret0)
    );

    imem_fetch_sequencer #(.HALT_ADDR(8'd5)) d1 (
        .Clk(Clk), .Reset_n(rst1_n), .Run(run1), .Step(step1), .Instruction(instr1),
        .Read_Address(pc1), .IR(ir1), .ALUSrc(as1), .MemRead(mr1), .MemWrite(mw1),
        .MemToReg(mtr1), .RegWrite(rw1), .Busy(busy1), .Halted(halted1), .Retired(ret1)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] prev_ret = 8'd0;
    logic saw8 = 1'b0;
    logic [15:0] busy_v, mr_v, mw_v, rw_v, mtr_v, as_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // each retirement of d0 pops the PC it must have left behind
    always @(negedge Clk) begin
        if (ret0 === prev_ret + 8'd1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_retire", {24'd0, pc0}, 32'hFFFF_FFFF);
            else chk("sb_retire_pc", {24'd0, pc0}, {24'd0, exp_q.pop_front()});
        end
        prev_ret = ret0;
        if (ir0 === 8'hAA) saw8 = 1'b1;
    end

    task automatic watch(input int n);
        busy_v = '0; mr_v = '0; mw_v = '0; rw_v = '0; mtr_v = '0; as_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            step = 1'b0;
            busy_v[i] = busy0; mr_v[i] = mr0; mw_v[i] = mw0;
            rw_v[i] = rw0; mtr_v[i] = mtr0; as_v[i] = as0;
        end
    endtask

    task automatic wait_ret0(input logic [7:0] tgt, input int budget);
        int k = 0;
        while (ret0 !== tgt && k < budget) begin
            @(negedge Clk);
            k++;
        end
        chk("wait_retired", {24'd0, ret0}, {24'd0, tgt});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h1B;
        end
        mem0[0] = 8'h55; mem0[1] = 8'h1B; mem0[2] = 8'h84; mem0[3] = 8'h55;
        mem0[4] = 8'h1B; mem0[5] = 8'h06; mem0[6] = 8'h27; mem0[7] = 8'hC1;
        mem0[8] = 8'hAA; mem0[9] = 8'h1B; mem0[10] = 8'h55; mem0[11] = 8'h2E;
        mem0[12] = 8'hC2;
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        rst1_n = 1'b0; run1 = 1'b0; step1 = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_pc", {24'd0, pc0}, 32'd0);
        chk("rst_ir", {24'd0, ir0}, 32'd0);
        chk("rst_retired", {24'd0, ret0}, 32'd0);
        chk("rst_flags", {25'd0, as0, mr0, mw0, mtr0, rw0, busy0, halted0}, 32'd0);
        chk("rst_d1_pc", {24'd0, pc1}, 32'd0);

        // single-step lw at PC 0
        rst_n = 1'b1;
        exp_q.push_back(8'd1);
        step = 1'b1;
        watch(8);
        chk("lw_busy", {16'd0, busy_v}, 32'h001F);
        chk("lw_memread", {16'd0, mr_v}, 32'h0008);
        chk("lw_regwrite", {16'd0, rw_v}, 32'h0010);
        chk("lw_memtoreg", {16'd0, mtr_v}, 32'h0010);
        chk("lw_alusrc", {16'd0, as_v}, 32'h0004);
        chk("lw_memwrite", {16'd0, mw_v}, 32'h0000);
        chk("lw_retired", {24'd0, ret0}, 32'd1);
        chk("lw_pc", {24'd0, pc0}, 32'd1);
        chk("lw_ir", {24'd0, ir0}, 32'h55);

        // add at PC 1, second Step pulse lands in DECODE
        exp_q.push_back(8'd2);
        step = 1'b1;
        @(negedge Clk);
        step = 1'b0;
        @(negedge Clk);
        step = 1'b1;
        watch(10);
        chk("step_ignored_busy", $countones(busy_v), 32'd2);
        chk("step_ignored_regwrite", {16'd0, rw_v}, 32'h0002);
        chk("step_ignored_retired", {24'd0, ret0}, 32'd2);
        chk("step_ignored_pc", {24'd0, pc0}, 32'd2);

        // sw at PC 2
        exp_q.push_back(8'd3);
        step = 1'b1;
        watch(8);
        chk("sw_memwrite", {16'd0, mw_v}, 32'h0008);
        chk("sw_alusrc", {16'd0, as_v}, 32'h000C);
        chk("sw_regwrite", {16'd0, rw_v}, 32'h0000);
        chk("sw_memread", {16'd0, mr_v}, 32'h0000);
        chk("sw_busy", {16'd0, busy_v}, 32'h000F);
        chk("sw_retired", {24'd0, ret0}, 32'd3);

        // free run from reset through both jumps
        rst_n = 1'b0;
        @(negedge Clk);
        chk("rerst_retired", {24'd0, ret0}, 32'd0);
        foreach (exp_q[i]) chk("sb_drained", 32'd1, 32'd0);
        for (int i = 1; i <= 7; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'd9); exp_q.push_back(8'd10); exp_q.push_back(8'd11);
        exp_q.push_back(8'd12); exp_q.push_back(8'd11); exp_q.push_back(8'd12);
        exp_q.push_back(8'd11); exp_q.push_back(8'd12); exp_q.push_back(8'd11);
        exp_q.push_back(8'd12);
        rst_n = 1'b1;
        run = 1'b1;
        wait_ret0(8'd12, 120);
        chk("run_pc_after_j12", {24'd0, pc0}, 32'd11);
        wait_ret0(8'd16, 80);
        run = 1'b0;
        wait_ret0(8'd17, 40);
        watch(4);
        chk("run_stop_busy", {16'd0, busy_v}, 32'h0000);
        chk("run_stop_pc", {24'd0, pc0}, 32'd12);
        chk("run_addr8_fetched", {31'd0, saw8}, 32'd0);

        // halt at address 5 on d1
        rst1_n = 1'b1;
        run1 = 1'b1;
        for (int k = 0; k < 100 && halted1 !== 1'b1; k++) @(negedge Clk);
        chk("halt_halted", {31'd0, halted1}, 32'd1);
        chk("halt_retired", {24'd0, ret1}, 32'd5);
        chk("halt_busy", {31'd0, busy1}, 32'd0);
        chk("halt_pc", {24'd0, pc1}, 32'd5);
        for (int k = 0; k < 6; k++) begin
            run1 = ~run1;
            step1 = ~step1;
            @(negedge Clk);
        end
        chk("halt_hold", {22'd0, pc1, halted1, busy1}, {22'd0, 8'd5, 1'b1, 1'b0});
        rst1_n = 1'b0;
        run1 = 1'b0;
        step1 = 1'b0;
        @(negedge Clk);
        chk("halt_reset", {22'd0, pc1, halted1, busy1}, 32'd0);
        rst1_n = 1'b1;

        // reset during MEM of lw, then j -2 at PC 0
        rst_n = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
        step = 1'b1;
        @(negedge Clk);
        step = 1'b0;
        repeat (3) @(negedge Clk);
        chk("abort_in_mem", {31'd0, mr0}, 32'd1);
        rst_n = 1'b0;
        @(negedge Clk);
        chk("abort_state", {14'd0, pc0, ret0, mr0, busy0}, 32'd0);
        rst_n = 1'b1;
        watch(6);
        chk("abort_no_regwrite", {16'd0, rw_v | busy_v}, 32'h0000);
        mem0[0] = 8'hC2;
        exp_q.push_back(8'd255);
        step = 1'b1;
        watch(6);
        chk("j_wrap_pc", {24'd0, pc0}, 32'd255);
        chk("j_wrap_halted", {31'd0, halted0}, 32'd1);
        chk("j_wrap_retired", {24'd0, ret0}, 32'd1);
        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
